ex_mem_stage: RTL and testbench

Pipeline register between the EX stage's 16-bit ALU and the MEM stage. It captures the ALU result Z and the five status flags (Sign, Zero, Carry, Parity, Overflow) and holds the architectural flag register. It resolves conditional branches against those flags and buffers up to two instructions in a valid/ready skid buffer, so a MEM-side stall never drops an ALU result.

---
 rtl/ex_mem_pkg.sv | 51 +++++
 rtl/ex_mem_if.sv | 34 +++
 rtl/ex_mem_stage_skid_fifo2.sv | 67 ++++++
 rtl/ex_mem_stage.sv | 62 ++++++
 tb/tb_ex_mem_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
package ex_mem_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned RD_IDX_W = 5;
   localparam int unsigned FLAG_W   = 5;
   localparam int unsigned COND_W   = 3;

   localparam int unsigned FLG_S  = 0;
   localparam int unsigned FLG_ZR = 1;
   localparam int unsigned FLG_CY = 2;
   localparam int unsigned FLG_P  = 3;
   localparam int unsigned FLG_V  = 4;

   typedef enum logic [COND_W-1:0] {
      COND_NEVER = 3'd0,
      COND_ALWAYS = 3'd1,
      COND_EQ    = 3'd2,
      COND_NE    = 3'd3,
      COND_NEG   = 3'd4,
      COND_CS    = 3'd5,
      COND_VS    = 3'd6,
      COND_PE    = 3'd7
   } cond_e;

   typedef struct packed {
      logic [DATA_W-1:0]   z;
      logic [RD_IDX_W-1:0] rd;
      logic                wr_en;
      logic                br_taken;
   } entry_t;

   // Branch resolution against a flag vector.
   function automatic logic cond_met(input cond_e c, input logic [FLAG_W-1:0] f);
      logic r;
      r = 1'b0;
      unique case (c)
         COND_NEVER:  r = 1'b0;
         COND_ALWAYS: r = 1'b1;
         COND_EQ:     r = f[FLG_ZR];
         COND_NE:     r = !f[FLG_ZR];
         COND_NEG:    r = f[FLG_S];
         COND_CS:     r = f[FLG_CY];
         COND_VS:     r = f[FLG_V];
         COND_PE:     r = f[FLG_P];
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX-to-MEM handshake bundle; the stage takes the slave modport.
interface ex_mem_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned RD_W  = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_z;
   logic [4:0]       in_flags;
   logic             in_set_flags;
   logic [2:0]       in_br_cond;
   logic [RD_W-1:0]  in_rd;
   logic             in_wr_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_z;
   logic [RD_W-1:0]  out_rd;
   logic             out_wr_en;
   logic             out_br_taken;
   logic [4:0]       flags_q;

   modport master (
      output flush, in_valid, in_z, in_flags, in_set_flags, in_br_cond, in_rd, in_wr_en,
             out_ready,
      input  in_ready, out_valid, out_z, out_rd, out_wr_en, out_br_taken, flags_q
   );

   modport slave (
      input  flush, in_valid, in_z, in_flags, in_set_flags, in_br_cond, in_rd, in_wr_en,
             out_ready,
      output in_ready, out_valid, out_z, out_rd, out_wr_en, out_br_taken, flags_q
   );
endinterface

// File: rtl/ex_mem_stage_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO with flush; head is always held in head_q.
module skid_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic [1:0]   count_q, count_d;
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic         push_c, pop_c;

   assign in_ready  = !rst && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign push_c    = in_valid && in_ready && !flush;
   assign pop_c     = out_valid && out_ready;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         unique case ({push_c, pop_c})
            2'b10: begin
               if (count_q == 2'd0) head_d = in_data;
               else                 tail_d = in_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            // Simultaneous push/pop: count holds, order preserved.
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = in_data;
               end else begin
                  head_d = tail_q;
                  tail_d = in_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: flag register, branch resolution at accept,
// and a 2-entry skid buffer so MEM stalls never drop an ALU result.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned RD_W  = RD_IDX_W
) (
   input logic   clk,
   input logic   rst,
   ex_mem_if.slave bus
);
   localparam int unsigned ENTRY_W = $bits(entry_t);

   logic [FLAG_W-1:0]  flags_reg;
   logic [FLAG_W-1:0]  flags_eff_c;
   logic               accept_c;
   logic               fifo_in_ready;
   entry_t             in_entry_c;
   entry_t             head;
   logic [ENTRY_W-1:0] head_bits;

   assign accept_c    = bus.in_valid && fifo_in_ready && !bus.flush;
   assign flags_eff_c = bus.in_set_flags ? bus.in_flags : flags_reg;

   always_comb begin
      in_entry_c          = '0;
      in_entry_c.z        = DATA_W'(bus.in_z);
      in_entry_c.rd       = RD_IDX_W'(bus.in_rd);
      in_entry_c.wr_en    = bus.in_wr_en;
      in_entry_c.br_taken = cond_met(cond_e'(bus.in_br_cond), flags_eff_c);
   end

   skid_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (fifo_in_ready),
      .in_data   (ENTRY_W'(in_entry_c)),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (head_bits)
   );

   assign head             = entry_t'(head_bits);
   assign bus.in_ready     = fifo_in_ready;
   assign bus.out_z        = WIDTH'(head.z);
   assign bus.out_rd       = RD_W'(head.rd);
   assign bus.out_wr_en    = head.wr_en;
   assign bus.out_br_taken = head.br_taken;
   assign bus.flags_q      = flags_reg;

   // Flags commit in program order at acceptance; flush never rolls them back.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_reg <= '0;
      end else if (accept_c && bus.in_set_flags) begin
         flags_reg <= bus.in_flags;
      end
   end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ex_mem_stage;
   logic clk = 1'b0;
   logic rst;

   ex_mem_if #(.WIDTH(16), .RD_W(5)) bus ();

   ex_mem_stage #(.WIDTH(16), .RD_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] z;
      logic [4:0]  rd;
      logic        wr;
      logic        br;
   } m_t;

   m_t         mq[$];
   logic [4:0] mflags;
   int         vectors = 0;
   int         miscompares = 0;

   function automatic logic m_cond(input logic [2:0] c, input logic [4:0] f);
      case (c)
         3'd0: return 1'b0;
         3'd1: return 1'b1;
         3'd2: return f[1];
         3'd3: return !f[1];
         3'd4: return f[0];
         3'd5: return f[2];
         3'd6: return f[4];
         default: return f[3];
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(!rst && mq.size() < 2));
      chk("flags_q", 32'(bus.flags_q), 32'(mflags));
      if (mq.size() != 0) begin
         chk("out_z", 32'(bus.out_z), 32'(mq[0].z));
         chk("out_rd", 32'(bus.out_rd), 32'(mq[0].rd));
         chk("out_wr_en", 32'(bus.out_wr_en), 32'(mq[0].wr));
         chk("out_br_taken", 32'(bus.out_br_taken), 32'(mq[0].br));
      end
   endtask

   // Advance model with the currently driven inputs, clock once, compare at negedge.
   task automatic tick();
      m_t  e;
      bit  acc;
      bit  pop;
      logic [4:0] eff;
      if (rst) begin
         mq.delete();
         mflags = '0;
      end else if (bus.flush) begin
         mq.delete();
      end else begin
         acc = bus.in_valid && (mq.size() < 2);
         pop = (mq.size() != 0) && bus.out_ready;
         eff = bus.in_set_flags ? bus.in_flags : mflags;
         if (pop) void'(mq.pop_front());
         if (acc) begin
            e.z  = bus.in_z;
            e.rd = bus.in_rd;
            e.wr = bus.in_wr_en;
            e.br = m_cond(bus.in_br_cond, eff);
            mq.push_back(e);
            if (bus.in_set_flags) mflags = bus.in_flags;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic offer(input logic [15:0] z, input logic [4:0] f, input logic set,
                        input logic [2:0] c, input logic [4:0] rd, input logic wr);
      bus.in_valid     = 1'b1;
      bus.in_z         = z;
      bus.in_flags     = f;
      bus.in_set_flags = set;
      bus.in_br_cond   = c;
      bus.in_rd        = rd;
      bus.in_wr_en     = wr;
   endtask

   task automatic idle();
      bus.in_valid     = 1'b0;
      bus.in_set_flags = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      idle();
      offer(16'h0, 5'h0, 1'b0, 3'd0, 5'd0, 1'b0);
      idle();
      mflags = '0;
      @(negedge clk);

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_z", 32'(bus.out_z), 32'd0);
      chk("rst_flags", 32'(bus.flags_q), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Overflow result with VS branch
      offer(16'h0FFF, 5'b10100, 1'b1, 3'd6, 5'd3, 1'b1);
      tick();
      chk("t1_z", 32'(bus.out_z), 32'h0FFF);
      chk("t1_br", 32'(bus.out_br_taken), 32'd1);
      chk("t1_flag_v", 32'(bus.flags_q[4]), 32'd1);
      idle();
      bus.out_ready = 1'b1;
      tick();

      // Back-to-back with MEM ready
      offer(16'h0001, 5'b00100, 1'b1, 3'd5, 5'd1, 1'b1);
      tick();
      chk("t2_first", 32'(bus.out_z), 32'h0001);
      offer(16'hFFFF, 5'b00001, 1'b1, 3'd4, 5'd2, 1'b1);
      tick();
      chk("t2_second", 32'(bus.out_z), 32'hFFFF);
      idle();
      tick();
      chk("t2_flags", 32'(bus.flags_q), 32'b00001);

      // MEM stall: two absorbed, third waits
      bus.out_ready = 1'b0;
      offer(16'h1111, 5'b0, 1'b0, 3'd1, 5'd4, 1'b1);
      tick();
      offer(16'h2222, 5'b0, 1'b0, 3'd0, 5'd5, 1'b0);
      tick();
      chk("t3_full", 32'(bus.in_ready), 32'd0);
      offer(16'h3333, 5'b0, 1'b0, 3'd1, 5'd6, 1'b1);
      tick();
      chk("t3_head", 32'(bus.out_z), 32'h1111);
      bus.out_ready = 1'b1;
      tick();
      chk("t3_after_pop", 32'(bus.out_z), 32'h2222);
      tick();
      chk("t3_third", 32'(bus.out_z), 32'h3333);
      idle();
      tick();
      chk("t3_empty", 32'(bus.out_valid), 32'd0);

      // EQ against stored flags without updating them
      offer(16'h0000, 5'b00010, 1'b1, 3'd0, 5'd7, 1'b0);
      tick();
      offer(16'h4444, 5'b11101, 1'b0, 3'd2, 5'd8, 1'b1);
      tick();
      chk("t4_br", 32'(bus.out_br_taken), 32'd1);
      chk("t4_flags", 32'(bus.flags_q), 32'b00010);
      idle();
      tick();

      // Flush with two buffered and an offer present
      bus.out_ready = 1'b0;
      offer(16'h5555, 5'b0, 1'b0, 3'd0, 5'd9, 1'b1);
      tick();
      offer(16'h6666, 5'b0, 1'b0, 3'd0, 5'd10, 1'b1);
      tick();
      offer(16'h7777, 5'b11111, 1'b1, 3'd1, 5'd11, 1'b1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      idle();
      chk("t5_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_flags", 32'(bus.flags_q), 32'b00010);
      chk("t5_ready", 32'(bus.in_ready), 32'd1);

      // Reset with one entry buffered
      offer(16'h8888, 5'b0, 1'b0, 3'd1, 5'd12, 1'b1);
      tick();
      idle();
      rst = 1'b1;
      tick();
      chk("t6_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_flags", 32'(bus.flags_q), 32'd0);
      chk("t6_ready_in_rst", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1 chk("t6_ready_after", 32'(bus.in_ready), 32'd1);
      @(negedge clk);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst              = ($urandom_range(0, 99) == 0);
         bus.flush        = ($urandom_range(0, 15) == 0);
         bus.in_valid     = ($urandom_range(0, 9) < 7);
         bus.out_ready    = ($urandom_range(0, 9) < 6);
         bus.in_z         = 16'($urandom);
         bus.in_flags     = 5'($urandom);
         bus.in_set_flags = 1'($urandom);
         bus.in_br_cond   = 3'($urandom);
         bus.in_rd        = 5'($urandom);
         bus.in_wr_en     = 1'($urandom);
         #1 chk("rand_in_ready", 32'(bus.in_ready), 32'(!rst && mq.size() < 2));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
